zeroriscy_multdiv_ctrl: RTL and testbench
=========================================

Name: zeroriscy_multdiv_ctrl

Overview:
- Iterative multiply/divide sequencer for the integer core; runs in the EX stage beside the ALU.
- Executes all RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at one add per cycle.
- Has no adder of its own: it borrows the ALU's 33-bit adder, driving the adder operands and reading back the sum.
- The ID stage holds the request until the block reports done.

Parameters:
- MD_CNT_W, 5, width of the iteration counter (32 iterations).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- mult_en_i  in  1  multiply request; held high until ready_o
- div_en_i  in  1  divide/remainder request; held high until ready_o
- operator_i  in  2  MD_OP_MULL / MD_OP_MULH / MD_OP_DIV / MD_OP_REM
- signed_mode_i  in  2  bit0 = op_a signed, bit1 = op_b signed (MULHSU = 2'b01)
- op_a_i  in  32  rs1 value
- op_b_i  in  32  rs2 value
- alu_req_o  out  1  block owns the ALU adder this cycle
- alu_adder_a_o  out  33  adder operand A; bit0 carries the carry-in
- alu_adder_b_o  out  33  adder operand B
- alu_adder_i  in  34  A+B from the shared adder, same cycle
- result_o  out  32  final result, valid only while ready_o = 1
- ready_o  out  1  single-cycle done pulse

Behaviour:
- Reset: state IDLE, counter 0, internal accumulator/operand/quotient registers 0.
  - Outputs at reset: ready_o = 0, alu_req_o = 0, result_o = 0.
- States: IDLE, ABS_A, ABS_B, COMP, LAST, CHANGE_SIGN, FINISH.
- Cycle 0 is the cycle in which IDLE sees an enable.
- Enables: mult_en_i and div_en_i are mutually exclusive. If both are high, mult_en_i wins; the bench must not drive both.
- Multiply path: IDLE → COMP → LAST → FINISH.
  - IDLE latches operands and clears the accumulator; the counter loads 31.
  - COMP runs 32 shift-add steps; counter 0 ends COMP.
  - LAST applies the sign correction for signed operands (subtracting the partial product of a signed MSB).
  - FINISH asserts ready_o.
  - MULL result = low 32 bits; MULH result = high 32 bits. Both take the same path: ready in cycle 34.
- Divide path: IDLE → ABS_A → ABS_B → COMP → CHANGE_SIGN → FINISH.
  - ABS_A and ABS_B negate negative signed operands through the adder (A = 1, B = ~x).
  - COMP runs 32 restoring steps. Each step compares (remainder << 1 | next bit) − |b| using the adder carry, then keeps or restores.
  - CHANGE_SIGN negates the quotient when sign(a) ≠ sign(b), and negates the remainder when a < 0.
  - Ready in cycle 36.
- Divide by zero:
  - Quotient = 0xFFFFFFFF (signed and unsigned).
  - Remainder = op_a_i unchanged.
  - Same 36-cycle latency.
- Signed overflow (0x80000000 / −1): quotient = 0x80000000, remainder = 0, same latency.
- Results always match RV32M semantics bit-exactly.
- alu_req_o = 1 in every state except IDLE and FINISH. The ALU must not be used by others while it is set.
- ready_o: high exactly one cycle (in FINISH); the next state is IDLE.
  - A fresh enable seen in the cycle after FINISH starts a new operation.
- Abort: if the active enable drops in any non-IDLE state, the next state is IDLE, no ready_o pulse, registers are not cleared.
- Reset mid-operation: the state is IDLE at the next edge and ready_o is 0.
- Operands are latched in IDLE; input changes during the operation are ignored.

Decomposition:
- Into zeroriscy_defines:
  - md_state_e enum covering the seven states.
  - Localparams MD_LAT_MUL = 34 and MD_LAT_DIV = 36.
  - Existing MD_OP_* codes reused.
- No sub-module: the adder is shared and external; the sequencer, counter and shift registers live in one module.

Test Plan:
- MULL signed 7 × −3 → result_o = 0xFFFFFFEB, ready_o in cycle 34 only, alu_req_o high cycles 1–33.
- MULH signed 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF(−1) × 2 → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD and REM → 0xFFFFFFFF, ready in cycle 36. DIVU 100 / 7 → 14, REMU → 2.
- DIVU 5 / 0 → 0xFFFFFFFF and REMU → 5. DIV 0x80000000 / −1 → 0x80000000, REM → 0.
- Abort: drop div_en_i at cycle 10 → IDLE at cycle 11, no ready_o. A following MULL 6 × 7 returns 42 in cycle 34 of the new operation.
- Reset: assert rst at cycle 20 of a MULH → ready_o = 0 and alu_req_o = 0 from the next edge. The next operation completes correctly.

Source files
------------

// File: rtl/zeroriscy_defines.sv
// Shared definitions for the multiply/divide sequencer: operator codes,
// sequencer states and operation latencies.
package zeroriscy_defines;

  localparam logic [1:0] MD_OP_MULL = 2'b00;
  localparam logic [1:0] MD_OP_MULH = 2'b01;
  localparam logic [1:0] MD_OP_DIV  = 2'b10;
  localparam logic [1:0] MD_OP_REM  = 2'b11;

  localparam int unsigned MD_LAT_MUL = 34;
  localparam int unsigned MD_LAT_DIV = 36;

  typedef enum logic [2:0] {
    MD_IDLE,
    MD_ABS_A,
    MD_ABS_B,
    MD_COMP,
    MD_LAST,
    MD_CHANGE_SIGN,
    MD_FINISH
  } md_state_e;

  // Adder B operand that, with A = {0, 1}, yields the two's complement of x.
  function automatic logic [32:0] md_negate_b(input logic [31:0] x);
    return {~x, 1'b1};
  endfunction

endpackage

// File: rtl/zeroriscy_multdiv_ctrl.sv
// Iterative RV32M multiply/divide sequencer; one add per cycle through the
// ALU's shared adder (operand bit0 carries the carry-in, sum read from [33:1]).
module zeroriscy_multdiv_ctrl
  import zeroriscy_defines::*;
#(
  parameter int unsigned MD_CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mult_en_i,
  input  logic        div_en_i,
  input  logic [1:0]  operator_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        alu_req_o,
  output logic [32:0] alu_adder_a_o,
  output logic [32:0] alu_adder_b_o,
  input  logic [33:0] alu_adder_i,
  output logic [31:0] result_o,
  output logic        ready_o
);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]         a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [1:0]          op_q, op_d;
  logic                mult_q, mult_d, sa_q, sa_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d, b_zero_q, b_zero_d;
  logic                ready_q, req_q;

  logic [32:0] add_a, add_b;
  logic        carry;
  logic [31:0] sum;
  logic        unused_sum_lsb;
  logic [31:0] mcand, shifted, sign_src;
  logic        mul_top, div_ge, neg_res, active_en;

  assign carry          = alu_adder_i[33];
  assign sum            = alu_adder_i[32:1];
  assign unused_sum_lsb = alu_adder_i[0];

  assign mcand   = b_q[0] ? a_q : 32'd0;
  // The accumulator is kept in 32 bits; the true 33rd bit of a signed add is
  // recovered from the carry and the operand signs.
  assign mul_top = sa_q ? (carry ^ acc_q[31] ^ mcand[31]) : carry;

  assign shifted = {acc_q[30:0], a_q[31]};
  assign div_ge  = carry | acc_q[31];

  assign sign_src = (op_q == MD_OP_DIV) ? a_q : acc_q;
  assign neg_res  = (op_q == MD_OP_DIV) ? ((a_neg_q ^ b_neg_q) & ~b_zero_q) : a_neg_q;

  assign active_en = mult_q ? mult_en_i : div_en_i;

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state_q)
      MD_ABS_A: begin
        add_a = {32'd0, 1'b1};
        add_b = md_negate_b(a_q);
      end
      MD_ABS_B: begin
        add_a = {32'd0, 1'b1};
        add_b = md_negate_b(b_q);
      end
      MD_COMP: begin
        if (mult_q) begin
          add_a = {acc_q, 1'b1};
          add_b = {mcand, 1'b0};
        end else begin
          add_a = {shifted, 1'b1};
          add_b = md_negate_b(b_q);
        end
      end
      MD_LAST: begin
        add_a = {acc_q, 1'b1};
        add_b = b_neg_q ? md_negate_b(a_q) : 33'd0;
      end
      MD_CHANGE_SIGN: begin
        add_a = {32'd0, 1'b1};
        add_b = neg_res ? md_negate_b(sign_src) : {sign_src, 1'b0};
      end
      default: begin
        add_a = '0;
        add_b = '0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    res_d    = res_q;
    op_d     = op_q;
    mult_d   = mult_q;
    sa_d     = sa_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;

    if (state_q != MD_IDLE && !active_en) begin
      state_d = MD_IDLE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (mult_en_i || div_en_i) begin
            mult_d   = mult_en_i;
            op_d     = operator_i;
            sa_d     = signed_mode_i[0];
            a_neg_d  = signed_mode_i[0] & op_a_i[31];
            b_neg_d  = signed_mode_i[1] & op_b_i[31];
            b_zero_d = (op_b_i == 32'd0);
            a_d      = op_a_i;
            b_d      = op_b_i;
            acc_d    = '0;
            cnt_d    = '1;
            state_d  = mult_en_i ? MD_COMP : MD_ABS_A;
          end
        end
        MD_ABS_A: begin
          if (a_neg_q) a_d = sum;
          state_d = MD_ABS_B;
        end
        MD_ABS_B: begin
          if (b_neg_q) b_d = sum;
          state_d = MD_COMP;
        end
        MD_COMP: begin
          if (mult_q) begin
            acc_d = {mul_top, sum[31:1]};
            b_d   = {sum[0], b_q[31:1]};
          end else begin
            acc_d = div_ge ? sum : shifted;
            a_d   = {a_q[30:0], div_ge};
          end
          cnt_d = cnt_q - MD_CNT_W'(1);
          if (cnt_q == '0) state_d = mult_q ? MD_LAST : MD_CHANGE_SIGN;
        end
        MD_LAST: begin
          res_d   = (op_q == MD_OP_MULL) ? b_q : sum;
          state_d = MD_FINISH;
        end
        MD_CHANGE_SIGN: begin
          res_d   = sum;
          state_d = MD_FINISH;
        end
        MD_FINISH: state_d = MD_IDLE;
        default:   state_d = MD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      res_q    <= '0;
      op_q     <= '0;
      mult_q   <= 1'b0;
      sa_q     <= 1'b0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      ready_q  <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      res_q    <= res_d;
      op_q     <= op_d;
      mult_q   <= mult_d;
      sa_q     <= sa_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      ready_q  <= (state_d == MD_FINISH);
      req_q    <= (state_d != MD_IDLE) && (state_d != MD_FINISH);
    end
  end

  assign alu_req_o     = req_q;
  assign ready_o       = ready_q;
  assign result_o      = res_q;
  assign alu_adder_a_o = add_a;
  assign alu_adder_b_o = add_b;

endmodule

// File: tb/tb_zeroriscy_multdiv_ctrl.sv
// Directed bench for the multiply/divide sequencer with a behavioural model
// of the shared ALU adder.
module tb_zeroriscy_multdiv_ctrl;
  import zeroriscy_defines::*;

  logic        clk;
  logic        rst;
  logic        mult_en_i, div_en_i;
  logic [1:0]  operator_i, signed_mode_i;
  logic [31:0] op_a_i, op_b_i;
  logic        alu_req_o;
  logic [32:0] alu_adder_a_o, alu_adder_b_o;
  logic [33:0] alu_adder_i;
  logic [31:0] result_o;
  logic        ready_o;

  zeroriscy_multdiv_ctrl #(.MD_CNT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .mult_en_i     (mult_en_i),
    .div_en_i      (div_en_i),
    .operator_i    (operator_i),
    .signed_mode_i (signed_mode_i),
    .op_a_i        (op_a_i),
    .op_b_i        (op_b_i),
    .alu_req_o     (alu_req_o),
    .alu_adder_a_o (alu_adder_a_o),
    .alu_adder_b_o (alu_adder_b_o),
    .alu_adder_i   (alu_adder_i),
    .result_o      (result_o),
    .ready_o       (ready_o)
  );

  assign alu_adder_i = {1'b0, alu_adder_a_o} + {1'b0, alu_adder_b_o};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        mult;
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic add_vec(input string n, input logic ml, input logic [1:0] op,
                         input logic [1:0] sm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] e, input int lat);
    vec_t v;
    v.name = n; v.mult = ml; v.op = op; v.sm = sm;
    v.a = a; v.b = b; v.exp = e; v.lat = lat;
    tbl.push_back(v);
  endtask

  task automatic check32(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic check_int(input string n, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          k;
    int          seen;
    int          req_ok;
    logic [31:0] res;
    @(posedge clk); #1;
    op_a_i = v.a; op_b_i = v.b; operator_i = v.op; signed_mode_i = v.sm;
    mult_en_i = v.mult; div_en_i = !v.mult;
    k = 0; seen = -1; req_ok = 1; res = '0;
    while (seen < 0 && k <= v.lat + 4) begin
      @(negedge clk);
      if (alu_req_o !== ((k >= 1) && (k < v.lat))) req_ok = 0;
      if (ready_o === 1'b1) begin
        seen = k;
        res  = result_o;
      end else begin
        @(posedge clk); #1;
        k++;
        if (k == 2) begin
          op_a_i = $urandom;
          op_b_i = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    mult_en_i = 1'b0; div_en_i = 1'b0;
    @(negedge clk);
    check_int({v.name, " ready cycle"}, seen, v.lat);
    check32({v.name, " result"}, res, v.exp);
    check_int({v.name, " alu_req window"}, req_ok, 1);
    check_int({v.name, " ready after finish"}, int'(ready_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ready_seen;
    vec_t v;

    add_vec("MULL 7*-3",       1'b1, MD_OP_MULL, 2'b11, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    add_vec("MULH min*min",    1'b1, MD_OP_MULH, 2'b11, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    add_vec("MULHU max*max",   1'b1, MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    add_vec("MULHSU -1*2",     1'b1, MD_OP_MULH, 2'b01, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    add_vec("MULL u",          1'b1, MD_OP_MULL, 2'b00, 32'h12345678, 32'd9,        32'hA3D70A38, 34);
    add_vec("MULH -7*3",       1'b1, MD_OP_MULH, 2'b11, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 34);
    add_vec("DIV -7/2",        1'b0, MD_OP_DIV,  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 36);
    add_vec("REM -7/2",        1'b0, MD_OP_REM,  2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 36);
    add_vec("DIVU 100/7",      1'b0, MD_OP_DIV,  2'b00, 32'd100,      32'd7,        32'd14,       36);
    add_vec("REMU 100/7",      1'b0, MD_OP_REM,  2'b00, 32'd100,      32'd7,        32'd2,        36);
    add_vec("DIVU 5/0",        1'b0, MD_OP_DIV,  2'b00, 32'd5,        32'd0,        32'hFFFFFFFF, 36);
    add_vec("REMU 5/0",        1'b0, MD_OP_REM,  2'b00, 32'd5,        32'd0,        32'd5,        36);
    add_vec("DIV ovf",         1'b0, MD_OP_DIV,  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 36);
    add_vec("REM ovf",         1'b0, MD_OP_REM,  2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        36);
    add_vec("DIV -7/0",        1'b0, MD_OP_DIV,  2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 36);
    add_vec("REM -7/0",        1'b0, MD_OP_REM,  2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 36);
    add_vec("DIV 7/-2",        1'b0, MD_OP_DIV,  2'b11, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 36);
    add_vec("REM 7/-2",        1'b0, MD_OP_REM,  2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        36);

    rst = 1'b1; mult_en_i = 1'b0; div_en_i = 1'b0;
    operator_i = '0; signed_mode_i = '0; op_a_i = '0; op_b_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_int("reset ready_o", int'(ready_o), 0);
    check_int("reset alu_req_o", int'(alu_req_o), 0);
    check32("reset result_o", result_o, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Abort a divide part-way through, then run a multiply.
    @(posedge clk); #1;
    op_a_i = 32'd100; op_b_i = 32'd7; operator_i = MD_OP_DIV; signed_mode_i = 2'b00;
    div_en_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 div_en_i = 1'b0;
    @(negedge clk);
    check_int("abort cycle10 alu_req", int'(alu_req_o), 1);
    @(negedge clk);
    check_int("abort cycle11 alu_req", int'(alu_req_o), 0);
    ready_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) ready_seen++;
    end
    check_int("abort no ready", ready_seen, 0);
    v.name = "MULL 6*7 after abort"; v.mult = 1'b1; v.op = MD_OP_MULL; v.sm = 2'b11;
    v.a = 32'd6; v.b = 32'd7; v.exp = 32'd42; v.lat = 34;
    run_vec(v);

    // Reset in the middle of a MULH.
    @(posedge clk); #1;
    op_a_i = 32'h80000000; op_b_i = 32'h80000000; operator_i = MD_OP_MULH; signed_mode_i = 2'b11;
    mult_en_i = 1'b1;
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_int("pre-reset alu_req", int'(alu_req_o), 1);
    @(negedge clk);
    check_int("mid reset ready_o", int'(ready_o), 0);
    check_int("mid reset alu_req_o", int'(alu_req_o), 0);
    rst = 1'b0; mult_en_i = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ready_o === 1'b1) ready_seen++;
    end
    check_int("after reset no ready", ready_seen, 0);
    v.name = "MULH after reset"; v.mult = 1'b1; v.op = MD_OP_MULH; v.sm = 2'b11;
    v.a = 32'h80000000; v.b = 32'h80000000; v.exp = 32'h40000000; v.lat = 34;
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
